// File: rtl/ccu_line_lock_pkg.sv
// Shared types and helpers for the cache-line lock scheduler.
// Addresses up to MaxAddrWidth bits are supported.
package ccu_line_lock_pkg;

  localparam int unsigned MaxAddrWidth = 128;

  typedef logic [MaxAddrWidth-1:0] line_t;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } ccu_lock_state_e;

  // Cache-line number of an address: the byte offset within the line is dropped.
  function automatic line_t line_addr(input line_t addr, input int unsigned offset);
    return addr >> offset;
  endfunction

endpackage

// File: rtl/ccu_line_lock_entry.sv
// One line-lock slot: holds the lock state and locked line, and compares it against every requester.
//   state  | meaning
//   IDLE   | no line held, port may be admitted
//   LOCKED | line held until the owning FSM pulses done_i
module ccu_line_lock_entry
  import ccu_line_lock_pkg::*;
#(
  parameter int unsigned NoPorts = 2
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   capture_i,
  input  logic                                   done_i,
  input  logic [MaxAddrWidth-1:0]                capture_line_i,
  input  logic [NoPorts-1:0][MaxAddrWidth-1:0]   cmp_line_i,
  output logic                                   locked_o,
  output logic [NoPorts-1:0]                     hit_o
);

  ccu_lock_state_e r_state;
  ccu_lock_state_e w_state_next;
  line_t           r_line;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (capture_i) w_state_next = LOCKED;
      LOCKED:  if (done_i)    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_line <= '0;
    end else if (capture_i && (r_state == IDLE)) begin
      r_line <= capture_line_i;
    end
  end

  assign locked_o = (r_state == LOCKED);

  always_comb begin
    hit_o = '0;
    for (int k = 0; k < NoPorts; k++) begin
      hit_o[k] = locked_o && (r_line == cmp_line_i[k]);
    end
  end

`ifndef SYNTHESIS
  // A release from a port that holds no lock points at a broken upstream FSM.
  a_done_in_idle: assert property (@(posedge clk_i) disable iff (!rst_ni)
    done_i |-> (r_state == LOCKED));
`endif

endmodule

// File: rtl/ccu_line_lock.sv
// Cache-line lock scheduler: admits one request per cycle, round-robin, only to lines no port holds.
// Optional conflict-stall counters on stall_cnt_o when CCU_LINE_LOCK_PERF_EN is defined.
module ccu_line_lock
  import ccu_line_lock_pkg::*;
#(
  parameter int unsigned NoPorts         = 2,
  parameter int unsigned AddrWidth       = 64,
  parameter int unsigned DcacheLineWidth = 128,
  parameter type         addr_t          = logic [AddrWidth-1:0]
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NoPorts-1:0]        req_valid_i,
  input  addr_t [NoPorts-1:0]       req_addr_i,
  output logic [NoPorts-1:0]        req_ready_o,
  input  logic [NoPorts-1:0]        done_i,
  output logic [NoPorts-1:0]        busy_o
`ifdef CCU_LINE_LOCK_PERF_EN
  ,
  output logic [NoPorts-1:0][31:0]  stall_cnt_o
`endif
);

  localparam int unsigned LineOffset = $clog2(DcacheLineWidth / 8);
  localparam int unsigned PtrWidth   = (NoPorts > 1) ? $clog2(NoPorts) : 1;

  logic [NoPorts-1:0][MaxAddrWidth-1:0] w_line;
  logic [NoPorts-1:0]                   w_hit [NoPorts];
  logic [NoPorts-1:0]                   w_locked;
  logic [NoPorts-1:0]                   w_conflict;
  logic [NoPorts-1:0]                   w_elig;
  logic [NoPorts-1:0]                   w_grant;
  logic                                 w_found;
  logic [PtrWidth-1:0]                  w_winner;
  logic [PtrWidth-1:0]                  w_rr_next;
  logic [PtrWidth-1:0]                  r_rr;

  always_comb begin
    w_line = '0;
    for (int i = 0; i < NoPorts; i++) begin
      w_line[i] = line_addr(line_t'(req_addr_i[i]), LineOffset);
    end
  end

  for (genvar g = 0; g < NoPorts; g++) begin : g_entry
    ccu_line_lock_entry #(
      .NoPorts(NoPorts)
    ) u_entry (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .capture_i      (w_grant[g]),
      .done_i         (done_i[g]),
      .capture_line_i (w_line[g]),
      .cmp_line_i     (w_line),
      .locked_o       (w_locked[g]),
      .hit_o          (w_hit[g])
    );
  end

  // Any locked entry (including the requester's own) holding the requested line blocks it.
  always_comb begin
    w_conflict = '0;
    for (int i = 0; i < NoPorts; i++) begin
      for (int j = 0; j < NoPorts; j++) begin
        w_conflict[i] = w_conflict[i] | w_hit[j][i];
      end
    end
  end

  assign w_elig = req_valid_i & ~w_locked & ~w_conflict;

  always_comb begin
    w_grant  = '0;
    w_winner = '0;
    w_found  = 1'b0;
    for (int k = 0; k < NoPorts; k++) begin
      int idx;
      idx = int'(r_rr) + k;
      if (idx >= int'(NoPorts)) idx = idx - int'(NoPorts);
      if (!w_found && w_elig[idx]) begin
        w_grant[idx] = 1'b1;
        w_winner     = PtrWidth'(idx);
        w_found      = 1'b1;
      end
    end
  end

  always_comb begin
    w_rr_next = r_rr;
    if (w_found) begin
      w_rr_next = (w_winner == PtrWidth'(NoPorts - 1)) ? '0 : w_winner + PtrWidth'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr <= '0;
    end else begin
      r_rr <= w_rr_next;
    end
  end

  // Ready is forced low while reset is asserted, even though the grant logic is combinational.
  assign req_ready_o = w_grant & {NoPorts{rst_ni}};
  assign busy_o      = w_locked;

`ifdef CCU_LINE_LOCK_PERF_EN
  logic [NoPorts-1:0][31:0] r_stall_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NoPorts; i++) begin
        if (req_valid_i[i] && !w_locked[i] && w_conflict[i] && (r_stall_cnt[i] != 32'hFFFF_FFFF)) begin
          r_stall_cnt[i] <= r_stall_cnt[i] + 32'd1;
        end
      end
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_ccu_line_lock.sv
// Bench for ccu_line_lock (NoPorts=2): directed vector table, corner sequences and a randomized model check.
module tb_ccu_line_lock;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       req_valid;
  logic [1:0][63:0] req_addr;
  logic [1:0]       req_ready;
  logic [1:0]       done;
  logic [1:0]       busy;
`ifdef CCU_LINE_LOCK_PERF_EN
  logic [1:0][31:0] stall_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ccu_line_lock #(
    .NoPorts         (2),
    .AddrWidth       (64),
    .DcacheLineWidth (128)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_addr_i  (req_addr),
    .req_ready_o (req_ready),
    .done_i      (done),
    .busy_o      (busy)
`ifdef CCU_LINE_LOCK_PERF_EN
    ,
    .stall_cnt_o (stall_cnt)
`endif
  );

  typedef struct {
    logic [1:0]  valid;
    logic [63:0] a0;
    logic [63:0] a1;
    logic [1:0]  done;
    logic [1:0]  ready;
    logic [1:0]  busy;
  } vec_t;

  vec_t tv [29];

  function automatic vec_t mk(input logic [1:0] v, input logic [63:0] a0, input logic [63:0] a1,
                              input logic [1:0] d, input logic [1:0] r, input logic [1:0] b);
    vec_t t;
    t.valid = v; t.a0 = a0; t.a1 = a1; t.done = d; t.ready = r; t.busy = b;
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid = '0;
    req_addr  = '0;
    done      = '0;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One cycle: drive, sample at the falling edge, advance.
  task automatic cyc(input logic [1:0] v, input logic [63:0] a0, input logic [63:0] a1,
                     input logic [1:0] d, input logic [1:0] exp_r, input string name);
    req_valid   = v;
    req_addr[0] = a0;
    req_addr[1] = a1;
    done        = d;
    @(negedge clk);
    check(name, req_ready, exp_r);
    tick();
  endtask

  task automatic run_table();
    tv[0]  = mk(2'b01, 64'h1000, 64'h0,    2'b00, 2'b01, 2'b00);
    tv[1]  = mk(2'b00, 64'h0,    64'h0,    2'b00, 2'b00, 2'b01);
    tv[2]  = mk(2'b00, 64'h0,    64'h0,    2'b01, 2'b00, 2'b01);
    tv[3]  = mk(2'b00, 64'h0,    64'h0,    2'b00, 2'b00, 2'b00);
    tv[4]  = mk(2'b01, 64'h1000, 64'h0,    2'b00, 2'b01, 2'b00);
    tv[5]  = mk(2'b10, 64'h0,    64'h1008, 2'b00, 2'b00, 2'b01);
    tv[6]  = mk(2'b10, 64'h0,    64'h1008, 2'b00, 2'b00, 2'b01);
    tv[7]  = mk(2'b10, 64'h0,    64'h1008, 2'b01, 2'b00, 2'b01);
    tv[8]  = mk(2'b10, 64'h0,    64'h1008, 2'b00, 2'b10, 2'b00);
    tv[9]  = mk(2'b00, 64'h0,    64'h0,    2'b00, 2'b00, 2'b10);
    tv[10] = mk(2'b01, 64'h1008, 64'h0,    2'b10, 2'b00, 2'b10);
    tv[11] = mk(2'b01, 64'h1008, 64'h0,    2'b00, 2'b01, 2'b00);
    tv[12] = mk(2'b01, 64'h2000, 64'h0,    2'b01, 2'b00, 2'b01);
    tv[13] = mk(2'b01, 64'h2000, 64'h0,    2'b00, 2'b01, 2'b00);
    tv[14] = mk(2'b00, 64'h0,    64'h0,    2'b01, 2'b00, 2'b01);
    tv[15] = mk(2'b11, 64'h3000, 64'h3008, 2'b00, 2'b10, 2'b00);
    tv[16] = mk(2'b01, 64'h3000, 64'h0,    2'b00, 2'b00, 2'b10);
    tv[17] = mk(2'b01, 64'h3000, 64'h0,    2'b10, 2'b00, 2'b10);
    tv[18] = mk(2'b01, 64'h3000, 64'h0,    2'b00, 2'b01, 2'b00);
    tv[19] = mk(2'b00, 64'h0,    64'h0,    2'b01, 2'b00, 2'b01);
    tv[20] = mk(2'b11, 64'h1000, 64'h2000, 2'b00, 2'b10, 2'b00);
    tv[21] = mk(2'b01, 64'h1000, 64'h0,    2'b00, 2'b01, 2'b10);
    tv[22] = mk(2'b00, 64'h0,    64'h0,    2'b00, 2'b00, 2'b11);
    tv[23] = mk(2'b11, 64'h4000, 64'h5000, 2'b11, 2'b00, 2'b11);
    tv[24] = mk(2'b11, 64'h4000, 64'h5000, 2'b00, 2'b10, 2'b00);
    tv[25] = mk(2'b01, 64'h4000, 64'h0,    2'b00, 2'b01, 2'b10);
    tv[26] = mk(2'b00, 64'h0,    64'h0,    2'b00, 2'b00, 2'b11);
    tv[27] = mk(2'b00, 64'h0,    64'h0,    2'b11, 2'b00, 2'b11);
    tv[28] = mk(2'b00, 64'h0,    64'h0,    2'b00, 2'b00, 2'b00);
    for (int i = 0; i < 29; i++) begin
      req_valid   = tv[i].valid;
      req_addr[0] = tv[i].a0;
      req_addr[1] = tv[i].a1;
      done        = tv[i].done;
      @(negedge clk);
      check($sformatf("vec%0d_ready", i), req_ready, tv[i].ready);
      check($sformatf("vec%0d_busy", i), busy, tv[i].busy);
      tick();
    end
    req_valid = '0;
    done      = '0;
  endtask

  task automatic run_fairness();
    int         gcnt [2];
    int         wait_c [2];
    int         max_wait;
    int         grants;
    int         guard;
    int         diff;
    logic [1:0] lk;
    gcnt = '{0, 0}; wait_c = '{0, 0};
    max_wait = 0; grants = 0; guard = 0; lk = 2'b00;
    req_addr[0] = 64'h10000;
    req_addr[1] = 64'h20000;
    while (grants < 100 && guard < 1000) begin
      guard++;
      req_valid = ~lk;
      done      = lk;
      @(negedge clk);
      check("fair_busy", busy, lk);
      for (int p = 0; p < 2; p++) begin
        if (req_ready[p]) begin
          gcnt[p]++; grants++; wait_c[p] = 0;
        end else if (req_valid[p]) begin
          wait_c[p]++;
          if (wait_c[p] > max_wait) max_wait = wait_c[p];
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (req_valid[p] && req_ready[p]) lk[p] = 1'b1;
        else if (done[p])                 lk[p] = 1'b0;
      end
      tick();
    end
    req_valid = '0;
    done      = lk;
    tick();
    done      = '0;
    check("fair_grants", grants, 100);
    diff = (gcnt[0] > gcnt[1]) ? gcnt[0] - gcnt[1] : gcnt[1] - gcnt[0];
    check("fair_diff_le1", (diff <= 1) ? 1 : 0, 1);
    check("fair_wait_le1", (max_wait <= 1) ? 1 : 0, 1);
  endtask

  task automatic run_random();
    bit          m_lk [2];
    longint      m_line [2];
    int          m_rr;
    bit          pend [2];
    logic [63:0] paddr [2];
    logic [1:0]  exp_r;
    logic [1:0]  exp_b;
    int          win;
    bit          found;
    bit          taken;
    m_lk = '{0, 0}; m_line = '{0, 0}; pend = '{0, 0}; paddr = '{64'h0, 64'h0}; m_rr = 0;
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 2) != 0) begin
          pend[p]  = 1'b1;
          paddr[p] = 64'h8000 + (64'($urandom_range(0, 3)) << 4) + 64'($urandom_range(0, 15));
        end
        req_valid[p] = pend[p];
        req_addr[p]  = paddr[p];
        done[p]      = m_lk[p] && ($urandom_range(0, 2) == 0);
      end
      exp_r = 2'b00; found = 1'b0; win = 0;
      for (int k = 0; k < 2; k++) begin
        int p;
        p = (m_rr + k) % 2;
        taken = 1'b0;
        for (int j = 0; j < 2; j++) begin
          if (m_lk[j] && m_line[j] == longint'(paddr[p] >> 4)) taken = 1'b1;
        end
        if (!found && pend[p] && !m_lk[p] && !taken) begin
          exp_r[p] = 1'b1; win = p; found = 1'b1;
        end
      end
      exp_b = {m_lk[1], m_lk[0]};
      @(negedge clk);
      check("rand_ready", req_ready, exp_r);
      check("rand_busy", busy, exp_b);
      for (int p = 0; p < 2; p++) if (done[p]) m_lk[p] = 1'b0;
      if (found) begin
        m_lk[win]   = 1'b1;
        m_line[win] = longint'(paddr[win] >> 4);
        pend[win]   = 1'b0;
        m_rr        = (win + 1) % 2;
      end
      tick();
    end
    req_valid = '0;
    done      = {m_lk[1], m_lk[0]};
    tick();
    done      = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n       = 1'b0;
    req_valid   = 2'b11;
    req_addr[0] = 64'h1000;
    req_addr[1] = 64'h2000;
    done        = '0;
    #2;
    check("rst_ready_low", req_ready, 2'b00);
    check("rst_busy_low", busy, 2'b00);
    do_reset();

    run_table();

    // Different lines requested together, pointer at 0 after reset: port 0 first, then port 1.
    do_reset();
    cyc(2'b11, 64'h1000, 64'h2000, 2'b00, 2'b01, "diff_first_p0");
    cyc(2'b10, 64'h1000, 64'h2000, 2'b00, 2'b10, "diff_second_p1");
    @(negedge clk);
    check("diff_both_busy", busy, 2'b11);
    tick();
    cyc(2'b00, 64'h0, 64'h0, 2'b11, 2'b00, "diff_release");

    do_reset();
    run_fairness();

    // Reset in the middle of two held locks.
    do_reset();
    cyc(2'b11, 64'h1000, 64'h2000, 2'b00, 2'b01, "rstmid_lock0");
    cyc(2'b10, 64'h1000, 64'h2000, 2'b00, 2'b10, "rstmid_lock1");
    req_valid   = 2'b11;
    req_addr[0] = 64'h6000;
    req_addr[1] = 64'h7000;
    #1 rst_n = 1'b0;
    #1;
    check("rstmid_ready_async", req_ready, 2'b00);
    check("rstmid_busy_async", busy, 2'b00);
    tick();
    check("rstmid_ready_held", req_ready, 2'b00);
    req_valid = '0;
    rst_n     = 1'b1;
    cyc(2'b10, 64'h0, 64'h1000, 2'b00, 2'b10, "rstmid_relock_old_line");
    @(negedge clk);
    check("rstmid_busy_after", busy, 2'b10);
    tick();
    cyc(2'b00, 64'h0, 64'h0, 2'b10, 2'b00, "rstmid_release");

    do_reset();
    run_random();

`ifdef CCU_LINE_LOCK_PERF_EN
    do_reset();
    check("perf_reset_cnt0", stall_cnt[0], 32'd0);
    check("perf_reset_cnt1", stall_cnt[1], 32'd0);
    cyc(2'b01, 64'h1000, 64'h0, 2'b00, 2'b01, "perf_lock0");
    for (int c = 0; c < 7; c++) begin
      cyc(2'b10, 64'h0, 64'h1008, (c == 6) ? 2'b01 : 2'b00, 2'b00, "perf_blocked");
    end
    cyc(2'b10, 64'h0, 64'h1008, 2'b00, 2'b10, "perf_grant1");
    req_valid = '0;
    @(negedge clk);
    check("perf_cnt1", stall_cnt[1], 32'd7);
    check("perf_cnt0", stall_cnt[0], 32'd0);
    tick();
    cyc(2'b00, 64'h0, 64'h0, 2'b10, 2'b00, "perf_release");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
